press_tally: RTL and testbench

- Downstream consumer of the debounced one-cycle press pulse ("clean") produced by the switch-cleanup stage.
- Keeps a running decimal (BCD) count of presses.
- Classifies each press group as a single press or a double press, using a programmable time window.
- Outputs drive the display/control logic; every output is registered.

---
 rtl/press_tally.sv | 157 +++++++++++++++
 tb/tb_press_tally.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/press_tally.sv
// -----------------------------------------------------------------------------
// press_tally
//
// Consumes the one-cycle debounced press pulse from the switch-cleanup stage.
// It keeps a decimal press count and classifies each press group as a single
// or a double press, using a programmable window.
//
// Parameters
//   DIGITS : number of BCD digits in the press count (1..8)
//   WINDOW : double-press window length in clock cycles (>= 2)
//   WIN_W  : window timer width, 2**WIN_W > WINDOW
//
// Ports
//   clock        : system clock, rising edge
//   reset        : asynchronous active-low reset
//   clean        : one-cycle press pulse, synchronous to clock
//   clear        : synchronous clear of count, overflow and classifier
//   count_bcd    : press count in BCD, digit 0 in bits [3:0]
//   single_press : one-cycle pulse, the group was a single press
//   double_press : one-cycle pulse, the group was a double press
//   overflow     : sticky flag, set when the count wraps to zero
//
// All outputs are registers. Priority each cycle is reset > clear > clean.
// -----------------------------------------------------------------------------
module press_tally #(
   parameter int DIGITS = 4,
   parameter int WINDOW = 250000,
   parameter int WIN_W  = 18
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clean,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  single_press,
   output logic                  double_press,
   output logic                  overflow
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   // Timer value seen in the last cycle of the window: the first press lands
   // in cycle k, the timer reads 0 in cycle k+1 and WINDOW-1 in cycle k+WINDOW.
   localparam logic [WIN_W-1:0] LAST_TICK = WIN_W'(WINDOW - 1);

   // Returns {carry_out, value + 1} in BCD. A digit advances only when every
   // lower digit is at 9. Those lower digits roll over to 0. Values above 9
   // are never produced. An out-of-range digit would also roll to 0.
   function automatic logic [4*DIGITS:0] bcd_increment(
      input logic [4*DIGITS-1:0] value
   );
      logic [4*DIGITS-1:0] result;
      logic                carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (value[4*i +: 4] >= 4'd9) begin
               result[4*i +: 4] = 4'd0;
               carry            = 1'b1;
            end else begin
               result[4*i +: 4] = value[4*i +: 4] + 4'd1;
               carry            = 1'b0;
            end
         end else begin
            result[4*i +: 4] = value[4*i +: 4];
         end
      end
      return {carry, result};
   endfunction

   state_t               state_r;
   logic [WIN_W-1:0]     timer_r;
   logic [4*DIGITS:0]    inc_s;
   logic [4*DIGITS-1:0]  count_next_s;
   logic                 wrap_s;

   // Next count and wrap indication for the current count.
   always_comb begin
      inc_s        = bcd_increment(count_bcd);
      count_next_s = inc_s[4*DIGITS-1:0];
      wrap_s       = inc_s[4*DIGITS];
   end

   // Press counter and sticky overflow flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_bcd <= {(4*DIGITS){1'b0}};
         overflow  <= 1'b0;
      end else if (clear) begin
         count_bcd <= {(4*DIGITS){1'b0}};
         overflow  <= 1'b0;
      end else if (clean) begin
         count_bcd <= count_next_s;
         if (wrap_s) begin
            overflow <= 1'b1;
         end else begin
            overflow <= overflow;
         end
      end else begin
         count_bcd <= count_bcd;
         overflow  <= overflow;
      end
   end

   // Single/double classifier with registered one-cycle event pulses.
   // In ARMED, a press takes precedence over the timeout. This holds even in
   // the last window cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         timer_r      <= {WIN_W{1'b0}};
         single_press <= 1'b0;
         double_press <= 1'b0;
      end else if (clear) begin
         state_r      <= IDLE;
         timer_r      <= {WIN_W{1'b0}};
         single_press <= 1'b0;
         double_press <= 1'b0;
      end else begin
         single_press <= 1'b0;
         double_press <= 1'b0;
         case (state_r)
            IDLE: begin
               timer_r <= {WIN_W{1'b0}};
               if (clean) begin
                  state_r <= ARMED;
               end else begin
                  state_r <= IDLE;
               end
            end
            ARMED: begin
               if (clean) begin
                  state_r      <= IDLE;
                  timer_r      <= {WIN_W{1'b0}};
                  double_press <= 1'b1;
               end else if (timer_r == LAST_TICK) begin
                  state_r      <= IDLE;
                  timer_r      <= {WIN_W{1'b0}};
                  single_press <= 1'b1;
               end else begin
                  state_r <= ARMED;
                  timer_r <= timer_r + WIN_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               timer_r <= {WIN_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_press_tally.sv
// -----------------------------------------------------------------------------
// tb_press_tally
//
// Self-checking bench for press_tally with DIGITS=2 and WINDOW=8.
//
// The reference model counts presses as a plain integer modulo 100. It
// classifies groups from the cycle number of the first press. A group is a
// double if another press arrives within WINDOW cycles after the first.
// Otherwise it is a single, reported WINDOW+1 cycles after the first press.
// -----------------------------------------------------------------------------
module tb_press_tally;

   localparam int DIGITS = 2;
   localparam int WINDOW = 8;
   localparam int WIN_W  = 4;

   logic       clock;
   logic       reset;
   logic       clean;
   logic       clear;
   logic [7:0] count_bcd;
   logic       single_press;
   logic       double_press;
   logic       overflow;

   press_tally #(.DIGITS(DIGITS), .WINDOW(WINDOW), .WIN_W(WIN_W)) dut (
      .clock        (clock),
      .reset        (reset),
      .clean        (clean),
      .clear        (clear),
      .count_bcd    (count_bcd),
      .single_press (single_press),
      .double_press (double_press),
      .overflow     (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model state
   int presses    = 0;
   bit m_ovf      = 1'b0;
   bit m_armed    = 1'b0;
   int m_first    = 0;
   bit exp_single = 1'b0;
   bit exp_double = 1'b0;

   // observed event cycles
   int seen_single = -1;
   int seen_double = -1;
   int n_single    = 0;
   int n_double    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [7:0] exp_bcd();
      return 8'(((presses / 10) << 4) | (presses % 10));
   endfunction

   task automatic model_reset();
      presses    = 0;
      m_ovf      = 1'b0;
      m_armed    = 1'b0;
      exp_single = 1'b0;
      exp_double = 1'b0;
   endtask

   // Advance the model by the inputs sampled in cycle cyc.
   task automatic model_step(input bit c, input bit cl);
      exp_single = 1'b0;
      exp_double = 1'b0;
      if (cl) begin
         presses = 0;
         m_ovf   = 1'b0;
         m_armed = 1'b0;
      end else begin
         if (c) begin
            presses++;
            if (presses == 100) begin
               presses = 0;
               m_ovf   = 1'b1;
            end
         end
         if (m_armed) begin
            if (c) begin
               exp_double = 1'b1;
               m_armed    = 1'b0;
            end else if (cyc - m_first == WINDOW) begin
               exp_single = 1'b1;
               m_armed    = 1'b0;
            end
         end else if (c) begin
            m_armed = 1'b1;
            m_first = cyc;
         end
      end
   endtask

   // One clock cycle. Inputs are driven away from the edge. Outputs are
   // checked 1 time unit after the edge.
   task automatic step(input bit c, input bit cl);
      clean = c;
      clear = cl;
      @(posedge clock);
      model_step(c, cl);
      cyc++;
      #1;
      check("count",    32'(count_bcd),    32'(exp_bcd()));
      check("overflow", 32'(overflow),     32'(m_ovf));
      check("single",   32'(single_press), 32'(exp_single));
      check("double",   32'(double_press), 32'(exp_double));
      if (single_press) begin seen_single = cyc; n_single++; end
      if (double_press) begin seen_double = cyc; n_double++; end
      clean = 1'b0;
      clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin
      int base;
      int b2;
      int dens;
      int ns_before;
      int nd_before;
      clean = 1'b0;
      clear = 1'b0;
      reset = 1'b0;

      // reset state
      #12;
      check("rst_count",  32'(count_bcd),    32'h0);
      check("rst_single", 32'(single_press), 32'h0);
      check("rst_double", 32'(double_press), 32'h0);
      check("rst_ovf",    32'(overflow),     32'h0);
      #10 reset = 1'b1;
      model_reset();
      cyc = 0;

      // 1: single clean at cycle 10
      idle(10);
      step(1'b1, 1'b0);
      check("t1_count", 32'(count_bcd), 32'h01);
      idle(20);
      check("t1_single_cyc", 32'(seen_single), 32'(10 + WINDOW + 1));
      check("t1_n_double", 32'(n_double), 32'h0);

      // 2: presses 4 cycles apart -> double
      base = cyc;
      ns_before = n_single;
      step(1'b1, 1'b0);
      idle(3);
      step(1'b1, 1'b0);
      idle(20);
      check("t2_count", 32'(count_bcd), 32'h03);
      check("t2_double_cyc", 32'(seen_double), 32'(base + 5));
      check("t2_no_single", 32'(n_single), 32'(ns_before));

      // 3: press in the last window cycle, then a late press starting a new group
      base = cyc;
      step(1'b1, 1'b0);
      idle(WINDOW - 1);
      step(1'b1, 1'b0);
      check("t3_double_cyc", 32'(seen_double), 32'(base + WINDOW + 1));
      idle(10);
      b2 = cyc;
      step(1'b1, 1'b0);
      idle(WINDOW);
      step(1'b1, 1'b0);
      check("t3_single_cyc1", 32'(seen_single), 32'(b2 + WINDOW + 1));
      idle(WINDOW + 4);
      check("t3_single_cyc2", 32'(seen_single), 32'(b2 + 2 * WINDOW + 2));

      // 4: wrap from 99 to 00 sets the sticky overflow
      step(1'b0, 1'b1);
      for (int i = 0; i < 99; i++) begin
         step(1'b1, 1'b0);
         idle(19);
      end
      check("t4_count99", 32'(count_bcd), 32'h99);
      check("t4_ovf0",    32'(overflow),  32'h0);
      step(1'b1, 1'b0);
      check("t4_count00", 32'(count_bcd), 32'h00);
      check("t4_ovf1",    32'(overflow),  32'h1);
      idle(20);
      step(1'b0, 1'b1);
      check("t4_ovf_clr", 32'(overflow),  32'h0);

      // 5: clean and clear together while ARMED
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0);
         idle(19);
      end
      step(1'b1, 1'b0);
      idle(2);
      check("t5_count5", 32'(count_bcd), 32'h05);
      ns_before = n_single;
      nd_before = n_double;
      step(1'b1, 1'b1);
      check("t5_count0", 32'(count_bcd), 32'h00);
      idle(2 * WINDOW);
      check("t5_no_single", 32'(n_single), 32'(ns_before));
      check("t5_no_double", 32'(n_double), 32'(nd_before));

      // 6: asynchronous reset in the middle of a window
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0);
         idle(19);
      end
      step(1'b1, 1'b0);
      idle(3);
      check("t6_count3", 32'(count_bcd), 32'h03);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_count", 32'(count_bcd),    32'h0);
      check("t6_rst_ovf",   32'(overflow),     32'h0);
      check("t6_rst_sp",    32'(single_press), 32'h0);
      model_reset();
      #3 reset = 1'b1;
      ns_before = n_single;
      idle(2 * WINDOW);
      check("t6_no_single", 32'(n_single), 32'(ns_before));

      // randomized traffic with varying press density, including held-high clean
      for (int seg = 0; seg < 20; seg++) begin
         dens = int'($urandom_range(1, 12));
         for (int i = 0; i < 150; i++) begin
            step(($urandom_range(0, dens - 1) == 0), ($urandom_range(0, 399) == 0));
         end
      end
      idle(2 * WINDOW + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
